ro_measure_ctrl: RTL

RO_MEASURE_CTRL -- requirements
Module: ro_measure_ctrl

---
 rtl/ro_measure_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ro_measure_ctrl.sv
// ---------------------------------------------------------------------------
// ro_measure_ctrl
//
// Purpose:
//   Register-controlled measurement controller for a ring-oscillator /
//   power-waster array. Software programs a measurement window, writes START,
//   and the block enables the array, waits a fixed settle time, and then
//   counts rising edges of the (asynchronous) oscillator output for exactly
//   WINDOW clock cycles. The result is readable through a small 4-register
//   window. A continuous mode re-arms the measurement window back-to-back
//   without dropping the enable.
//
// Register map (byte offsets from BASE_ADDR):
//   +0x0 CTRL   write: bit0 START, bit1 CONT, bit2 ABORT
//               read : {29'b0, 1'b0, CONT, 1'b0}
//   +0x4 WINDOW measurement length in clock cycles (0 skips measuring)
//   +0x8 COUNT  edges counted in the last/current window (saturating)
//   +0xC STATUS {29'b0, OVF, DONE, busy}
//   other addresses read as 32'hdeaddead
//
// Ports:
//   clk_main_a0  in   single clock, all state lives here
//   rst_main_a0  in   asynchronous active-high reset
//   wready       in   one-cycle register write strobe
//   wr_addr      in   [31:0] write address
//   wdata        in   [31:0] write data
//   arvalid_q    in   read request
//   araddr_q     in   [31:0] read address
//   rready       in   read-data accept
//   rvalid       out  read data valid
//   rdata        out  [31:0] read data
//   rresp        out  [1:0] read response, always OKAY
//   ro_enable    out  enable to the oscillator array
//   ro_out       in   oscillator output, asynchronous to clk_main_a0
//   busy         out  high while settling or measuring
// ---------------------------------------------------------------------------
module ro_measure_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0510
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_a0,
  input  logic        wready,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wdata,
  input  logic        arvalid_q,
  input  logic [31:0] araddr_q,
  input  logic        rready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        ro_enable,
  input  logic        ro_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [31:0] ADDR_CTRL   = BASE_ADDR;
  localparam logic [31:0] ADDR_WINDOW = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_COUNT  = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'hC;
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [31:0] COUNT_MAX   = 32'hFFFF_FFFF;
  localparam logic [31:0] BAD_ADDR    = 32'hdeaddead;

  state_t      state_q;
  state_t      state_d;

  logic [7:0]  settle_cnt;
  logic [31:0] win_cnt;
  logic [31:0] window_reg;
  logic [31:0] window_shadow;
  logic [31:0] count;
  logic        cont;
  logic        restart_q;
  logic        restart_d;
  logic        done_flag;
  logic        ovf;

  logic        sync1;
  logic        sync2;
  logic        sync_prev;
  logic        edge_flag;

  logic        wr_ctrl;
  logic        wr_window;
  logic        abort_cmd;
  logic        start_cmd;
  logic        stop_cmd;

  logic        load_settle;
  logic        load_window;
  logic        clear_count;
  logic        enter_done;
  logic        clear_ovf;
  logic        clear_done;
  logic        count_en;
  logic        ro_enable_d;
  logic        busy_d;
  logic [31:0] read_mux;

  // Write decode. ABORT wins over START when both bits are set in one write;
  // a CTRL write with neither START nor ABORT is a "stop", which only has an
  // effect in DONE (return to IDLE).
  assign wr_ctrl   = wready && (wr_addr == ADDR_CTRL);
  assign wr_window = wready && (wr_addr == ADDR_WINDOW);
  assign abort_cmd = wr_ctrl && wdata[2];
  assign start_cmd = wr_ctrl && wdata[0] && !wdata[2];
  assign stop_cmd  = wr_ctrl && !wdata[0] && !wdata[2];

  assign edge_flag = sync2 && !sync_prev;
  assign rresp     = 2'b00;

  // Two-flop synchronizer for the free-running oscillator output, plus one
  // more flop holding the previous synchronized sample for edge detection.
  always_ff @(posedge clk_main_a0 or posedge rst_main_a0) begin
    if (rst_main_a0) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= ro_out;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // State register.
  always_ff @(posedge clk_main_a0 or posedge rst_main_a0) begin
    if (rst_main_a0) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes. The settle and window counters are
  // compared against 1 so that SETTLE lasts SETTLE_CYCLES cycles and MEASURE
  // lasts exactly WINDOW cycles. The window length used is the copy taken at
  // START, so WINDOW writes mid-run only matter for the next START. ABORT
  // overrides everything decided in the case statement.
  always_comb begin
    state_d     = state_q;
    load_settle = 1'b0;
    load_window = 1'b0;
    clear_count = 1'b0;
    enter_done  = 1'b0;
    clear_ovf   = 1'b0;
    clear_done  = 1'b0;
    restart_d   = restart_q;

    case (state_q)
      IDLE: begin
        if (start_cmd) begin
          state_d     = SETTLE;
          load_settle = 1'b1;
          clear_count = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt == 8'd1) begin
          if (window_shadow == 32'd0) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d     = MEASURE;
            load_window = 1'b1;
          end
        end
      end
      MEASURE: begin
        if (win_cnt == 32'd1) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        if (start_cmd) begin
          state_d     = SETTLE;
          load_settle = 1'b1;
          clear_count = 1'b1;
        end else if (stop_cmd) begin
          state_d   = IDLE;
          clear_ovf = 1'b1;
        end else if (restart_q) begin
          state_d     = MEASURE;
          load_window = 1'b1;
          clear_count = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_cmd) begin
      state_d     = IDLE;
      load_settle = 1'b0;
      load_window = 1'b0;
      clear_count = 1'b0;
      enter_done  = 1'b0;
      clear_ovf   = 1'b0;
      clear_done  = 1'b1;
    end

    // A fresh START also starts a fresh status.
    if (load_settle) begin
      clear_ovf = 1'b1;
    end
    if (clear_ovf) begin
      clear_done = 1'b1;
    end

    // Continuous mode is decided on the way into DONE; a zero window never
    // re-arms, otherwise the restarted window counter would start at zero.
    if (enter_done) begin
      restart_d = cont && (window_shadow != 32'd0);
    end else if (state_d != DONE) begin
      restart_d = 1'b0;
    end

    ro_enable_d = (state_d == SETTLE) || (state_d == MEASURE) ||
                  ((state_d == DONE) && restart_d);
    busy_d      = (state_d == SETTLE) || (state_d == MEASURE);

    // An ABORT in the same cycle as an edge freezes COUNT at its old value.
    count_en    = (state_q == MEASURE) && edge_flag && !abort_cmd;
  end

  // ro_enable and busy are registered from the next state so the enable to
  // the oscillator array comes straight off a flop.
  always_ff @(posedge clk_main_a0 or posedge rst_main_a0) begin
    if (rst_main_a0) begin
      ro_enable <= 1'b0;
      busy      <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      ro_enable <= ro_enable_d;
      busy      <= busy_d;
      restart_q <= restart_d;
    end
  end

  // Settle and window down-counters.
  always_ff @(posedge clk_main_a0 or posedge rst_main_a0) begin
    if (rst_main_a0) begin
      settle_cnt <= 8'd0;
      win_cnt    <= 32'd0;
    end else begin
      if (load_settle) begin
        settle_cnt <= SETTLE_LOAD;
      end else if (state_q == SETTLE) begin
        settle_cnt <= settle_cnt - 8'd1;
      end

      if (load_window) begin
        win_cnt <= window_shadow;
      end else if (state_q == MEASURE) begin
        win_cnt <= win_cnt - 32'd1;
      end
    end
  end

  // Software-visible configuration: CONT is taken from every CTRL write, and
  // WINDOW is copied into a shadow at START for use by the running FSM.
  always_ff @(posedge clk_main_a0 or posedge rst_main_a0) begin
    if (rst_main_a0) begin
      cont          <= 1'b0;
      window_reg    <= 32'd0;
      window_shadow <= 32'd0;
    end else begin
      if (wr_ctrl) begin
        cont <= wdata[1];
      end
      if (wr_window) begin
        window_reg <= wdata;
      end
      if (load_settle) begin
        window_shadow <= window_reg;
      end
    end
  end

  // Edge counter with saturation. An edge arriving with COUNT already at
  // its maximum sets OVF instead of wrapping.
  always_ff @(posedge clk_main_a0 or posedge rst_main_a0) begin
    if (rst_main_a0) begin
      count <= 32'd0;
      ovf   <= 1'b0;
    end else begin
      if (clear_count) begin
        count <= 32'd0;
      end else if (count_en && (count != COUNT_MAX)) begin
        count <= count + 32'd1;
      end

      if (clear_ovf) begin
        ovf <= 1'b0;
      end else if (count_en && (count == COUNT_MAX)) begin
        ovf <= 1'b1;
      end
    end
  end

  // Sticky DONE status: set on every entry to DONE (including each window
  // in continuous mode), cleared by START, ABORT or a stop write in DONE.
  always_ff @(posedge clk_main_a0 or posedge rst_main_a0) begin
    if (rst_main_a0) begin
      done_flag <= 1'b0;
    end else begin
      if (enter_done) begin
        done_flag <= 1'b1;
      end else if (clear_done) begin
        done_flag <= 1'b0;
      end
    end
  end

  // Read data selection from the current register values.
  always_comb begin
    read_mux = BAD_ADDR;
    if (araddr_q == ADDR_CTRL) begin
      read_mux = {29'd0, 1'b0, cont, 1'b0};
    end else if (araddr_q == ADDR_WINDOW) begin
      read_mux = window_reg;
    end else if (araddr_q == ADDR_COUNT) begin
      read_mux = count;
    end else if (araddr_q == ADDR_STATUS) begin
      read_mux = {29'd0, ovf, done_flag, busy};
    end
  end

  // Read channel: one outstanding read. Requests arriving while data is
  // still waiting for rready are dropped, and rdata returns to zero once
  // the data has been accepted.
  always_ff @(posedge clk_main_a0 or posedge rst_main_a0) begin
    if (rst_main_a0) begin
      rvalid <= 1'b0;
      rdata  <= 32'd0;
    end else begin
      if (rvalid && rready) begin
        rvalid <= 1'b0;
        rdata  <= 32'd0;
      end else if (arvalid_q && !rvalid) begin
        rvalid <= 1'b1;
        rdata  <= read_mux;
      end
    end
  end

endmodule
